// File: rtl/tff_counter_arbiter_if.sv
// Handshake bundle between the requesters and the shared-counter arbiter.
// master = requester side, slave = arbiter side.
interface tff_counter_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] dir;
  logic [N_REQ-1:0] gnt;
  logic             done;
  logic             busy;
  logic [WIDTH-1:0] count;

  modport master (
    output req,
    output dir,
    input  gnt,
    input  done,
    input  busy,
    input  count
  );

  modport slave (
    input  req,
    input  dir,
    output gnt,
    output done,
    output busy,
    output count
  );
endinterface

// File: rtl/tff_counter_arbiter.sv
// Round-robin arbiter sharing one toggle-enabled up/down counter among N_REQ requesters.
// Optional: define TFF_ARB_SATURATE_EN to make the counter saturate instead of wrapping.
module tff_counter_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  tff_counter_arbiter_if.slave    bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic             wdir_q, wdir_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             arb_found;
  logic [PW-1:0]    arb_win;
  logic [CW-1:0]    arb_cand;
  logic [PW-1:0]    win_next;

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] t_vec;

  // Toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
  assign t_up[0] = 1'b1;
  assign t_dn[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_toggle
      assign t_up[gi] = &count_q[gi-1:0];
      assign t_dn[gi] = &(~count_q[gi-1:0]);
    end
  endgenerate

  always_comb begin
    t_vec = wdir_q ? t_up : t_dn;
`ifdef TFF_ARB_SATURATE_EN
    if ((wdir_q && (&count_q)) || (!wdir_q && !(|count_q))) begin
      t_vec = '0;
    end
`endif
  end

  // First requesting index scanning ptr, ptr+1, ... modulo N_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_cand = CW'(ptr_q) + CW'(k);
      if (arb_cand >= CW'(N_REQ)) begin
        arb_cand = arb_cand - CW'(N_REQ);
      end
      if (!arb_found && bus.req[arb_cand[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_win   = arb_cand[PW-1:0];
      end
    end
  end

  assign win_next = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    wdir_d  = wdir_q;
    gnt_d   = '0;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_UPDATE: begin
        if (arb_found) begin
          win_d   = arb_win;
          wdir_d  = bus.dir[arb_win];
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << arb_win;
          busy_d  = 1'b1;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // ptr advances here so arbitration during UPDATE already sees it.
        count_d = count_q ^ t_vec;
        ptr_d   = win_next;
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = ST_UPDATE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      wdir_q  <= 1'b0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wdir_q  <= wdir_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_tff_counter_arbiter.sv
// Directed, table-driven bench for tff_counter_arbiter (N_REQ=4, WIDTH=4).
module tb_tff_counter_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  tff_counter_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  tff_counter_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [N-1:0] req;
    logic [N-1:0] dir;
    logic [N-1:0] gnt;
    logic         done;
    logic         busy;
    logic [W-1:0] count;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [N-1:0] g, input logic d,
                           input logic b, input logic [W-1:0] c);
    checks++;
    if (bus.gnt !== g || bus.done !== d || bus.busy !== b || bus.count !== c ||
        (|bus.gnt && bus.done)) begin
      failures++;
      $display("FAIL %s: got gnt=%b done=%b busy=%b count=%0d, want gnt=%b done=%b busy=%b count=%0d",
               name, bus.gnt, bus.done, bus.busy, bus.count, g, d, b, c);
    end else begin
      $display("ok   %s: gnt=%b done=%b busy=%b count=%0d", name, bus.gnt, bus.done, bus.busy, bus.count);
    end
  endtask

  task automatic do_step(input int idx, input bit up, input logic [W-1:0] c0,
                         input logic [W-1:0] c1);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    bus.req = oh;
    bus.dir = up ? oh : '0;
    tick();
    check_out($sformatf("step r%0d %s grant", idx, up ? "up" : "dn"), oh, 1'b0, 1'b1, c0);
    bus.req = '0;
    tick();
    check_out($sformatf("step r%0d %s done", idx, up ? "up" : "dn"), '0, 1'b1, 1'b1, c1);
    tick();
    check_out($sformatf("step r%0d %s idle", idx, up ? "up" : "dn"), '0, 1'b0, 1'b0, c1);
  endtask

  initial begin
    logic [W-1:0] sat_up;
    logic [W-1:0] sat_dn;
`ifdef TFF_ARB_SATURATE_EN
    sat_up = 4'd15;
    sat_dn = 4'd0;
`else
    sat_up = 4'd0;
    sat_dn = 4'd15;
`endif

    //           req      dir      gnt      done  busy  count
    vecs[0]  = {4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'd0};
    vecs[1]  = {4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'd1};
    vecs[2]  = {4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd1};
    vecs[3]  = {4'b0101, 4'b0101, 4'b0100, 1'b0, 1'b1, 4'd1};
    vecs[4]  = {4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'd2};
    vecs[5]  = {4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'd2};
    vecs[6]  = {4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'd3};
    vecs[7]  = {4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd3};
    vecs[8]  = {4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1, 4'd3};
    vecs[9]  = {4'b0100, 4'b0110, 4'b0000, 1'b1, 1'b1, 4'd2};
    vecs[10] = {4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd2};
    vecs[11] = {4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd2};

    bus.req = '0;
    bus.dir = '0;
    reset = 1'b0;
    tick();
    tick();
    check_out("reset state", '0, 1'b0, 1'b0, '0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus.req = vecs[i].req;
      bus.dir = vecs[i].dir;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].count);
    end

    // Fairness: all four requesting up continuously from a fresh reset.
    reset = 1'b0;
    bus.req = '0;
    tick();
    tick();
    reset = 1'b1;
    bus.req = 4'b1111;
    bus.dir = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i % 2 == 0) begin
        check_out($sformatf("rr cyc%0d", i), N'(1) << ((i / 2) % N), 1'b0, 1'b1, W'(i / 2));
      end else begin
        check_out($sformatf("rr cyc%0d", i), '0, 1'b1, 1'b1, W'((i + 1) / 2));
      end
    end
    bus.req = '0;
    tick();
    check_out("rr end", '0, 1'b0, 1'b0, 4'd8);

    // Climb to 15, then step across the top boundary.
    for (int v = 8; v < 15; v++) begin
      do_step(0, 1'b1, W'(v), W'(v + 1));
    end
    do_step(0, 1'b1, 4'd15, sat_up);
    if (sat_up != 4'd0) begin
      for (int v = 15; v > 0; v--) begin
        do_step(1, 1'b0, W'(v), W'(v - 1));
      end
    end
    do_step(1, 1'b0, 4'd0, sat_dn);

    // Reset during GRANT; ptr is 2 here, so a post-reset grant to r0 shows ptr cleared.
    bus.req = 4'b0100;
    bus.dir = 4'b0100;
    tick();
    check_out("pre-reset grant", 4'b0100, 1'b0, 1'b1, sat_dn);
    reset = 1'b0;
    bus.req = '0;
    tick();
    check_out("reset in grant", '0, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    bus.req = 4'b1111;
    bus.dir = 4'b1111;
    tick();
    check_out("post-reset ptr0", 4'b0001, 1'b0, 1'b1, 4'd0);
    bus.req = '0;
    tick();
    check_out("post-reset done", '0, 1'b1, 1'b1, 4'd1);
    tick();
    check_out("post-reset idle", '0, 1'b0, 1'b0, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
